// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits LSB first, optional parity, 1 or 2 stop bits, timed by uart_clk_en_i.
// Define UART_TX_CTS_EN to add cts_n_i, a synchronised active-low clear-to-send that gates data_ready_o.
module uart_tx #(
  parameter int    ClkDivVal = 16,
  parameter string ParityBit = "none",
  parameter int    StopBits  = 1
) (
  input  logic       clk_i,
  input  logic       reset_i,
`ifdef UART_TX_CTS_EN
  input  logic       cts_n_i,
`endif
  input  logic       uart_clk_en_i,
  input  logic [7:0] data_i,
  input  logic       data_valid_i,
  output logic       data_ready_o,
  output logic       uart_txd_o,
  output logic       busy_o,
  output logic       tx_done_o
);

  localparam int              CntW    = (ClkDivVal > 1) ? $clog2(ClkDivVal) : 1;
  localparam logic [CntW-1:0] CntMax  = CntW'(ClkDivVal - 1);
  localparam bit              ParEn   = (ParityBit != "none");
  localparam bit              ParOdd  = (ParityBit == "odd");
  localparam bit              TwoStop = (StopBits == 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] tick_q, tick_d;
  logic [2:0]      bit_q, bit_d;
  logic            stop_q, stop_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic            txd_q, txd_d;
  logic            done_q, done_d;
  logic            cts_ok;
  logic            accept;
  logic            bit_end;

`ifdef UART_TX_CTS_EN
  logic [1:0] cts_sync_q;

  // Reset to "not clear" so nothing is accepted until the pin has been seen low.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) cts_sync_q <= 2'b11;
    else         cts_sync_q <= {cts_sync_q[0], cts_n_i};
  end
  assign cts_ok = ~cts_sync_q[1];
`else
  assign cts_ok = 1'b1;
`endif

  assign data_ready_o = (state_q == IDLE) & ~reset_i & cts_ok;
  assign accept       = data_valid_i & data_ready_o;
  assign bit_end      = uart_clk_en_i & (tick_q == CntMax);

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    par_d   = par_q;
    done_d  = 1'b0;
    txd_d   = 1'b1;

    if (state_q != IDLE && uart_clk_en_i) tick_d = bit_end ? '0 : tick_q + CntW'(1);

    case (state_q)
      IDLE: begin
        tick_d = '0;
        if (accept) begin
          state_d = START;
          shift_d = data_i;
          par_d   = (^data_i) ^ ParOdd;
          bit_d   = 3'd0;
          stop_d  = 1'b0;
        end
      end
      START:  if (bit_end) state_d = DATA;
      DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = ParEn ? PARITY : STOP;
        end
      end
      PARITY: if (bit_end) state_d = STOP;
      STOP: begin
        if (bit_end) begin
          if (TwoStop && !stop_q) begin
            stop_d = 1'b1;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Line value is registered for the state being entered, so it changes on the same edge.
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      PARITY:  txd_d = par_d;
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= 3'd0;
      stop_q  <= 1'b0;
      shift_q <= 8'd0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
      done_q  <= done_d;
    end
  end

  assign uart_txd_o = txd_q;
  assign busy_o     = (state_q != IDLE);
  assign tx_done_o  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three parity/stop configurations checked every cycle against a frame-vector model,
// plus directed frame, gap, reset and slow-tick scenarios.
module tb_uart_tx;
  localparam int DIV = 16;
  localparam int NL  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, clk_en;
  logic [NL-1:0] vld, rdy, txd, busy, done;
  logic [7:0]    din [NL];
  int            total = 0, bad = 0;
  int            en_mode = 0, cyc = 0;
  bit            chk_on = 1'b0;

`ifdef UART_TX_CTS_EN
  logic       cts_n;
  logic [1:0] cts_h = 2'b11;
  function automatic bit cts_ok(); return !cts_h[1]; endfunction
`else
  function automatic bit cts_ok(); return 1'b1; endfunction
`endif

  // lane 0: no parity, 1 stop; lane 1: even, 2 stop; lane 2: odd, 1 stop
  function automatic int par_of(input int l); return l; endfunction
  function automatic int stops_of(input int l); return (l == 1) ? 2 : 1; endfunction

  uart_tx #(.ClkDivVal(DIV), .ParityBit("none"), .StopBits(1)) u_l0 (
    .clk_i(clk), .reset_i(rst),
`ifdef UART_TX_CTS_EN
    .cts_n_i(cts_n),
`endif
    .uart_clk_en_i(clk_en), .data_i(din[0]), .data_valid_i(vld[0]), .data_ready_o(rdy[0]),
    .uart_txd_o(txd[0]), .busy_o(busy[0]), .tx_done_o(done[0]));

  uart_tx #(.ClkDivVal(DIV), .ParityBit("even"), .StopBits(2)) u_l1 (
    .clk_i(clk), .reset_i(rst),
`ifdef UART_TX_CTS_EN
    .cts_n_i(cts_n),
`endif
    .uart_clk_en_i(clk_en), .data_i(din[1]), .data_valid_i(vld[1]), .data_ready_o(rdy[1]),
    .uart_txd_o(txd[1]), .busy_o(busy[1]), .tx_done_o(done[1]));

  uart_tx #(.ClkDivVal(DIV), .ParityBit("odd"), .StopBits(1)) u_l2 (
    .clk_i(clk), .reset_i(rst),
`ifdef UART_TX_CTS_EN
    .cts_n_i(cts_n),
`endif
    .uart_clk_en_i(clk_en), .data_i(din[2]), .data_valid_i(vld[2]), .data_ready_o(rdy[2]),
    .uart_txd_o(txd[2]), .busy_o(busy[2]), .tx_done_o(done[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: each accepted byte becomes a frame bit vector walked one bit per DIV ticks.
  logic [11:0] fr [NL];
  int          nb [NL], idx [NL], tk [NL];
  bit          act [NL], edone [NL];

  always @(posedge clk or posedge rst) begin
    bit ok;
    ok = cts_ok();
    for (int l = 0; l < NL; l++) begin
      edone[l] = 1'b0;
      if (rst) begin
        act[l] = 1'b0;
      end else if (!act[l]) begin
        if (vld[l] && ok) begin
          fr[l] = '1;
          fr[l][0] = 1'b0;
          for (int i = 0; i < 8; i++) fr[l][1+i] = din[l][i];
          nb[l] = 9;
          if (par_of(l) != 0) begin
            fr[l][9] = (^din[l]) ^ (par_of(l) == 2);
            nb[l] = 10;
          end
          nb[l] += stops_of(l);
          idx[l] = 0;
          tk[l]  = 0;
          act[l] = 1'b1;
        end
      end else if (clk_en) begin
        tk[l]++;
        if (tk[l] == DIV) begin
          tk[l] = 0;
          idx[l]++;
          if (idx[l] == nb[l]) begin
            act[l]   = 1'b0;
            edone[l] = 1'b1;
          end
        end
      end
    end
`ifdef UART_TX_CTS_EN
    cts_h = rst ? 2'b11 : {cts_h[0], cts_n};
`endif
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int l = 0; l < NL; l++) begin
        check($sformatf("txd%0d", l),  txd[l],  act[l] ? fr[l][idx[l]] : 1'b1);
        check($sformatf("busy%0d", l), busy[l], act[l]);
        check($sformatf("done%0d", l), done[l], edone[l]);
        check($sformatf("rdy%0d", l),  rdy[l],  !act[l] && !rst && cts_ok());
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
    cyc++;
    case (en_mode)
      0:       clk_en = 1'b1;
      1:       clk_en = (cyc % 4 == 0);
      default: clk_en = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic wait_idle(input int l);
    int n = 0;
    while (busy[l] !== 1'b0 && n < 5000) begin
      tick();
      n++;
    end
    check($sformatf("idle_wait%0d", l), busy[l], 1'b0);
    tick();
  endtask

  task automatic frame(input int l, input logic [7:0] b, input logic [11:0] exp_fr, input int nbits);
    int m;
    logic [11:0] seen;
    seen = '1;
    check($sformatf("rdy_pre%0d", l), rdy[l], 1'b1);
    din[l] = b;
    vld[l] = 1'b1;
    tick();
    vld[l] = 1'b0;
    m = 0;
    while (done[l] !== 1'b1 && m < 1000) begin
      if (m % DIV == DIV / 2 && m / DIV < 12) seen[m/DIV] = txd[l];
      tick();
      m++;
    end
    check($sformatf("frame_len%0d", l), m, nbits * DIV);
    check($sformatf("frame_bits%0d", l), seen, exp_fr);
    tick();
  endtask

  task automatic gap_test();
    int m = 0, run = 0;
    din[1] = 8'h00;
    vld[1] = 1'b1;
    tick();
    din[1] = 8'hFF;
    while (txd[1] !== 1'b1 && m < 400) begin tick(); m++; end
    while (txd[1] === 1'b1 && run < 400) begin tick(); run++; end
    vld[1] = 1'b0;
    check("gap_high", run, 2 * DIV + 1);
    check("gap_start", txd[1], 1'b0);
    wait_idle(1);
  endtask

  task automatic reset_mid();
    din[0] = 8'h00;
    vld[0] = 1'b1;
    tick();
    vld[0] = 1'b0;
    repeat (4 * DIV + 5) tick();
    check("pre_rst_txd", txd[0], 1'b0);
    rst = 1'b1;
    #1;
    check("rst_txd", txd[0], 1'b1);
    check("rst_busy", busy[0], 1'b0);
    tick();
    rst = 1'b0;
    tick();
    frame(0, 8'h55, {2'b11, 1'b1, 8'h55, 1'b0}, 10);
  endtask

  task automatic slow_tick_test();
    int m = 0, run = 0;
    en_mode = 1;
    din[0] = 8'h0F;
    vld[0] = 1'b1;
    tick();
    vld[0] = 1'b0;
    while (txd[0] !== 1'b1 && m < 400) begin tick(); m++; end
    while (txd[0] === 1'b1 && run < 1000) begin tick(); run++; end
    check("slow_high_run", run, 4 * 4 * DIV);
    wait_idle(0);
    en_mode = 0;
  endtask

  initial begin
    rst = 1'b1;
    clk_en = 1'b0;
    vld = '0;
    for (int l = 0; l < NL; l++) din[l] = 8'h00;
`ifdef UART_TX_CTS_EN
    cts_n = 1'b0;
`endif
    repeat (3) tick();
    for (int l = 0; l < NL; l++) begin
      check($sformatf("reset_txd%0d", l),  txd[l],  1'b1);
      check($sformatf("reset_rdy%0d", l),  rdy[l],  1'b0);
      check($sformatf("reset_busy%0d", l), busy[l], 1'b0);
      check($sformatf("reset_done%0d", l), done[l], 1'b0);
    end
    chk_on = 1'b1;
    rst = 1'b0;
    repeat (3) tick();

    frame(0, 8'hA5, {2'b11, 1'b1, 8'hA5, 1'b0}, 10);
    frame(1, 8'h07, {1'b1, 1'b1, 1'b1, 8'h07, 1'b0}, 12);
    frame(2, 8'h07, {1'b1, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
    gap_test();
    reset_mid();
    slow_tick_test();

`ifdef UART_TX_CTS_EN
    cts_n = 1'b1;
    repeat (3) tick();
    vld[0] = 1'b1;
    for (int i = 0; i < 50; i++) begin
      check("cts_rdy", rdy[0], 1'b0);
      check("cts_txd", txd[0], 1'b1);
      tick();
    end
    vld[0] = 1'b0;
    cts_n = 1'b0;
    repeat (3) tick();
`endif

    for (int mode = 1; mode <= 2; mode++) begin
      en_mode = mode;
      for (int c = 0; c < 6000; c++) begin
        for (int l = 0; l < NL; l++) begin
          if ($urandom_range(0, 7) == 0) begin
            vld[l] = 1'($urandom_range(0, 1));
            din[l] = 8'($urandom);
          end
        end
        rst = ($urandom_range(0, 2999) == 0);
`ifdef UART_TX_CTS_EN
        if ($urandom_range(0, 199) == 0) cts_n = ~cts_n;
`endif
        tick();
      end
    end
    rst = 1'b0;
    vld = '0;
    en_mode = 0;
`ifdef UART_TX_CTS_EN
    cts_n = 1'b0;
`endif
    for (int l = 0; l < NL; l++) wait_idle(l);

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired before completion");
    $fatal(1, "watchdog");
  end

endmodule
